// File: rtl/store_narrow_unit.sv
// Store-path formatter: narrows a register value to byte/halfword/word lanes with byte enables,
// behind a 2-entry FIFO. Define STORE_ALIGN_CHECK_EN to flag misaligned halfword/word stores.
module store_narrow_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [3:0]  out_be,
  output logic        out_err,
  output logic        out_trunc
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        err;
    logic        trunc;
  } entry_t;

  entry_t      fmt;
  entry_t      head;
  entry_t      mem_q [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;
`ifdef STORE_ALIGN_CHECK_EN
  logic        misalign;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    fmt      = '0;
    fmt.addr = {in_addr[31:2], 2'b00};
`ifdef STORE_ALIGN_CHECK_EN
    misalign = 1'b0;
`endif
    case (in_size)
      2'b00: begin
        fmt.data  = {4{in_data[7:0]}};
        fmt.be    = 4'b0001 << in_addr[1:0];
        fmt.trunc = in_data[31:8] != {24{in_data[7]}};
      end
      2'b01: begin
        fmt.data  = {2{in_data[15:0]}};
        fmt.be    = 4'b0011 << {in_addr[1], 1'b0};
        fmt.trunc = in_data[31:16] != {16{in_data[15]}};
`ifdef STORE_ALIGN_CHECK_EN
        misalign  = in_addr[0];
`endif
      end
      2'b10: begin
        fmt.data  = in_data;
        fmt.be    = 4'b1111;
`ifdef STORE_ALIGN_CHECK_EN
        misalign  = |in_addr[1:0];
`endif
      end
      default: begin
        fmt.data  = in_data;
        fmt.err   = 1'b1;
      end
    endcase
`ifdef STORE_ALIGN_CHECK_EN
    // Misaligned entries still travel through the FIFO, just with no lanes enabled.
    if (misalign) begin
      fmt.err = 1'b1;
      fmt.be  = 4'b0000;
    end
`endif
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; outputs are gated by out_valid, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= fmt;
  end

  assign head      = out_valid ? mem_q[head_q] : '0;
  assign out_addr  = head.addr;
  assign out_data  = head.data;
  assign out_be    = head.be;
  assign out_err   = head.err;
  assign out_trunc = head.trunc;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: vector table, hand sequences and a randomized
// run against a lane-level reference model with a FIFO scoreboard.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_err;
  logic        out_trunc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        err;
    logic        trunc;
  } entry_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_err;
    logic        e_trunc;
  } vec_t;

  entry_t q[$];
  vec_t   vecs[8];

  store_narrow_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_err   (out_err),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: a store of n bytes covers lanes [start, start+n), each lane k carries byte k%n.
  function automatic entry_t model(input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] data);
    entry_t e;
    int     n, a, start;
    longint v, lim;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.data  = data;
    e.be    = 4'b0000;
    e.err   = 1'b0;
    e.trunc = 1'b0;
    if (size == 2'd3) begin
      e.err = 1'b1;
      return e;
    end
    n     = 1 << size;
    a     = int'(addr[1:0]);
    start = a - (a % n);
    for (int k = 0; k < 4; k++) begin
      e.data[8*k +: 8] = data[8*(k % n) +: 8];
      e.be[k]          = (k >= start) && (k < start + n);
    end
    v       = longint'($signed(data));
    lim     = longint'(1) << (8*n - 1);
    e.trunc = (n < 4) && ((v < -lim) || (v >= lim));
`ifdef STORE_ALIGN_CHECK_EN
    if ((a % n) != 0) begin
      e.err = 1'b1;
      e.be  = 4'b0000;
    end
`endif
    return e;
  endfunction

  task automatic compare(input string tag);
    entry_t exp;
    check({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, ":in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() != 0) exp = q[0];
    else exp = '{addr: '0, data: '0, be: '0, err: 1'b0, trunc: 1'b0};
    check({tag, ":out_addr"},  out_addr,        exp.addr);
    check({tag, ":out_data"},  out_data,        exp.data);
    check({tag, ":out_be"},    32'(out_be),     32'(exp.be));
    check({tag, ":out_err"},   32'(out_err),    32'(exp.err));
    check({tag, ":out_trunc"}, 32'(out_trunc),  32'(exp.trunc));
  endtask

  // Drive one cycle from a negedge, advance the scoreboard at the posedge, compare at the next negedge.
  task automatic step(input logic v, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy, input string tag);
    logic acc, pop;
    entry_t e;
    in_valid  = v;
    in_size   = sz;
    in_addr   = a;
    in_data   = d;
    out_ready = rdy;
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() != 0);
    e   = model(sz, a, d);
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    compare(tag);
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 3)
      0:       return r;
      1:       return {{24{r[7]}}, r[7:0]};
      default: return {{16{r[15]}}, r[15:0]};
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    in_size   = '0;
    out_ready = 1'b0;

    vecs[0] = '{2'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 1'b0, 1'b1};
    vecs[1] = '{2'd1, 32'h0000_2002, 32'hFFFF_8001, 32'h0000_2000, 32'h8001_8001, 4'b1100, 1'b0, 1'b0};
    vecs[2] = '{2'd1, 32'h0000_2002, 32'h0001_8001, 32'h0000_2000, 32'h8001_8001, 4'b1100, 1'b0, 1'b1};
`ifdef STORE_ALIGN_CHECK_EN
    vecs[3] = '{2'd2, 32'h0000_3001, 32'h1234_5678, 32'h0000_3000, 32'h1234_5678, 4'b0000, 1'b1, 1'b0};
    vecs[7] = '{2'd1, 32'h0000_6001, 32'h0000_8000, 32'h0000_6000, 32'h8000_8000, 4'b0000, 1'b1, 1'b1};
`else
    vecs[3] = '{2'd2, 32'h0000_3001, 32'h1234_5678, 32'h0000_3000, 32'h1234_5678, 4'b1111, 1'b0, 1'b0};
    vecs[7] = '{2'd1, 32'h0000_6001, 32'h0000_8000, 32'h0000_6000, 32'h8000_8000, 4'b0011, 1'b0, 1'b1};
`endif
    vecs[4] = '{2'd3, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0000_4000, 32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 32'h0000_5001, 32'hFFFF_FF80, 32'h0000_5000, 32'h8080_8080, 4'b0010, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 32'h0000_6000, 32'h0000_7FFF, 32'h0000_6000, 32'h7FFF_7FFF, 4'b0011, 1'b0, 1'b0};

    @(negedge clk);
    @(negedge clk);
    compare("reset");
    rst = 1'b0;

    // Directed vectors: accept, check head one edge later, then pop.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].size, vecs[i].addr, vecs[i].data, 1'b0, "vec_push");
      check($sformatf("vec%0d:valid", i), 32'(out_valid),  32'd1);
      check($sformatf("vec%0d:addr", i),  out_addr,        vecs[i].e_addr);
      check($sformatf("vec%0d:data", i),  out_data,        vecs[i].e_data);
      check($sformatf("vec%0d:be", i),    32'(out_be),     32'(vecs[i].e_be));
      check($sformatf("vec%0d:err", i),   32'(out_err),    32'(vecs[i].e_err));
      check($sformatf("vec%0d:trunc", i), 32'(out_trunc),  32'(vecs[i].e_trunc));
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "vec_pop");
    end

    // Backpressure: three back-to-back requests while memory stalls.
    step(1'b1, 2'd0, 32'h0000_0100, 32'h0000_0011, 1'b0, "bp_a");
    step(1'b1, 2'd1, 32'h0000_0202, 32'h0000_2222, 1'b0, "bp_b");
    check("bp_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'd2, 32'h0000_0300, 32'h3333_3333, 1'b0, "bp_c_blocked");
    check("bp_stable_addr", out_addr, 32'h0000_0100);
    step(1'b1, 2'd2, 32'h0000_0300, 32'h3333_3333, 1'b0, "bp_c_blocked2");
    check("bp_stable_data", out_data, 32'h1111_1111);
    step(1'b1, 2'd2, 32'h0000_0300, 32'h3333_3333, 1'b1, "bp_pop_a");
    check("bp_head_b", out_data, 32'h2222_2222);
    step(1'b1, 2'd2, 32'h0000_0300, 32'h3333_3333, 1'b1, "bp_pop_b_push_c");
    check("bp_head_c", out_data, 32'h3333_3333);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "bp_pop_c");
    check("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: one request per cycle, no bubbles after the first.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'($urandom_range(0, 2)), $urandom, rand_data(), 1'b1, "stream");
      check("stream_ready", 32'(in_ready), 32'd1);
      check("stream_valid", 32'(out_valid), 32'd1);
    end
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "stream_drain");

    // Reset with two entries queued, out_ready high during the flushing edge.
    step(1'b1, 2'd0, 32'h0000_0701, 32'h0000_0077, 1'b0, "rst_fill1");
    step(1'b1, 2'd0, 32'h0000_0702, 32'h0000_0078, 1'b0, "rst_fill2");
    rst = 1'b1;
    step(1'b1, 2'd2, 32'h0000_0800, 32'h0000_0088, 1'b1, "rst_flush");
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data", out_data, 32'd0);
    step(1'b1, 2'd1, 32'h0000_0902, 32'hFFFF_9999, 1'b0, "post_rst_push");
    check("post_rst_data", out_data, 32'h9999_9999);
    check("post_rst_be", 32'(out_be), 32'h0000_000C);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, "post_rst_pop");

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 4) != 0, 2'($urandom), $urandom, rand_data(), ($urandom % 3) != 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path formatter between the EX/MEM pipeline register and the data-memory write port. It narrows a 32-bit register value to byte, halfword or word, places it on the correct byte lanes and generates byte enables. It flags values that do not survive narrowing: a value that is not the sign-extension of its low byte or halfword. A 2-entry buffer with valid/ready handshakes on both sides decouples pipeline issue from memory acceptance.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  store request present
- in_ready  out  1  unit can accept a request this cycle
- in_data  in  32  register value to store
- in_addr  in  32  byte address
- in_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- out_valid  out  1  formatted write available at head
- out_ready  in  1  memory accepts head this cycle
- out_addr  out  32  word address, {in_addr[31:2],2'b00}
- out_data  out  32  lane-aligned write data
- out_be  out  4  byte enables; bit k = lane k = byte address offset k (little-endian)
- out_err  out  1  misaligned or reserved-size request (out_be forced 0000)
- out_trunc  out  1  narrowing lost information

## Operation
- Accept when in_valid && in_ready; format combinationally; write into 2-entry FIFO (head/tail pointers, 2-bit count).
- Byte: out_data = {4{in_data[7:0]}}, out_be = 0001 << addr[1:0].
- Halfword: out_data = {2{in_data[15:0]}}, out_be = 0011 << {addr[1],1'b0}.
- Word: out_data = in_data, out_be = 1111.
- Reserved size 11: out_err=1, out_be=0000, out_data=in_data.
- out_trunc for byte: in_data[31:8] != {24{in_data[7]}}; for halfword: in_data[31:16] != {16{in_data[15]}}; always 0 for word and reserved.
- out_trunc is informational only; the write still proceeds with the narrowed data.
- Head entry drives all out_* signals; pop when out_valid && out_ready.

## Timing
- Reset: count=0, pointers=0, in_ready=1 in the cycle after reset; out_valid=0, out_addr=0, out_data=0, out_be=0, out_err=0, out_trunc=0.
- Latency: request accepted at edge N appears with out_valid=1 after edge N (one cycle). There is no combinational path from in_* to out_*.
- in_ready = (count != 2), registered from count. It does not depend on out_ready in the same cycle.
- Push with pop at count=1: count stays 1 and the new entry becomes head next cycle.
- Push with pop at count=2 cannot occur because in_ready=0.
- Pop at count=0 is ignored.
- While out_valid && !out_ready, all out_* stay stable.
- FIFO order is strict; no reordering or merging.
- rst mid-operation flushes both entries, drops in-flight data and returns to reset values on the next edge.
- out_valid drops to 0 after the flushing edge, even if out_ready was asserted in that cycle.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - halfword with addr[0]=1 sets out_err=1 and out_be=0000;
  - word with addr[1:0]!=00 sets out_err=1 and out_be=0000;
  - the entry is still delivered through the FIFO.
- STORE_ALIGN_CHECK_EN undefined:
  - halfword ignores addr[0]; word ignores addr[1:0];
  - out_be is computed from the remaining bits as above;
  - out_err asserts only for reserved size 11.

## Test plan
- Byte store of in_data=0x000000A5 at addr 0x1003 -> out_addr=0x1000, out_data=0xA5A5A5A5, out_be=1000, out_trunc=1, out_err=0, out_valid one cycle after accept.
- Halfword 0xFFFF8001 at addr 0x2002 -> out_data=0x80018001, out_be=1100, out_trunc=0; repeat with 0x00018001 -> out_trunc=1.
- Word at 0x3001:
  - with STORE_ALIGN_CHECK_EN -> out_err=1, out_be=0000;
  - without it -> out_err=0, out_be=1111, out_addr=0x3000.
- out_ready held 0 while issuing 3 back-to-back requests -> first two accepted, in_ready=0 on the third until one pop; outputs stay stable; release delivers all three in order.
- Continuous in_valid and out_ready=1 -> one request per cycle, count never exceeds 1, no bubbles after the first.
- rst asserted with 2 entries queued -> next cycle out_valid=0, all outputs 0, in_ready=1; the next request is delivered correctly.
